// File: rtl/encrypter_scheduler_pkg.sv
// Shared constants for the encrypter array datapath.
package encrypter_scheduler_pkg;

  // Number of encrypter cores in the array (power of two, at least 2)
  localparam int NUM_ENCRYPTERS  = 4;
  // Width of a plaintext block, a key rotation and a result
  localparam int ENCRYPTER_WIDTH = 32;

endpackage : encrypter_scheduler_pkg

// File: rtl/encrypter_scheduler_if.sv
// Block/encrypter/result bus bundle of the encrypter scheduler.
// The slave modport is the scheduler's view; master is the surrounding logic.
interface encrypter_scheduler_if
  import encrypter_scheduler_pkg::*;
#(
  parameter int NUM_ENC = NUM_ENCRYPTERS,
  parameter int DATA_W  = ENCRYPTER_WIDTH
) ();

  // Upstream block handshake
  logic                      blk_valid;
  logic                      blk_ready;
  logic [DATA_W-1:0]         blk_data;
  logic [DATA_W-1:0]         blk_key_rot;

  // Encrypter array side
  logic [NUM_ENC-1:0]        enc_ready;
  logic [NUM_ENC-1:0]        enc_program;
  logic [DATA_W-1:0]         enc_data;
  logic [DATA_W-1:0]         enc_key_rot;
  logic [NUM_ENC-1:0]        enc_done;
  logic [NUM_ENC*DATA_W-1:0] enc_result;

  // In-order result stream and status
  logic                      out_valid;
  logic                      out_ready;
  logic [DATA_W-1:0]         out_data;
  logic                      busy;
  logic                      err_spurious;

  modport slave (
    input  blk_valid, blk_data, blk_key_rot,
    input  enc_ready, enc_done, enc_result,
    input  out_ready,
    output blk_ready,
    output enc_program, enc_data, enc_key_rot,
    output out_valid, out_data, busy, err_spurious
  );

  modport master (
    output blk_valid, blk_data, blk_key_rot,
    output enc_ready, enc_done, enc_result,
    output out_ready,
    input  blk_ready,
    input  enc_program, enc_data, enc_key_rot,
    input  out_valid, out_data, busy, err_spurious
  );

endinterface : encrypter_scheduler_if

// File: rtl/encrypter_scheduler_enc_order_fifo.sv
// Order queue of core indices in acceptance order. Depth equals the core
// count; an extra pointer bit separates full from empty.
module enc_order_fifo
  import encrypter_scheduler_pkg::*;
#(
  parameter  int DEPTH = NUM_ENCRYPTERS,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [IDX_W-1:0] push_idx,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [IDX_W-1:0] head
);

  logic [IDX_W-1:0] mem_q [DEPTH];
  logic [IDX_W-1:0] mem_d [DEPTH];
  logic [IDX_W:0]   wr_ptr_q, wr_ptr_d;
  logic [IDX_W:0]   rd_ptr_q, rd_ptr_d;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[IDX_W] != rd_ptr_q[IDX_W]) &&
                 (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]);
  assign head  = mem_q[rd_ptr_q[IDX_W-1:0]];

  // Next-state for storage and pointers; push on full or pop on empty is ignored
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push && !full) begin
      mem_d[wr_ptr_q[IDX_W-1:0]] = push_idx;
      wr_ptr_d                   = wr_ptr_q + (IDX_W+1)'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop && !empty) begin
      rd_ptr_d = rd_ptr_q + (IDX_W+1)'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
  end

  // Queue state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

endmodule : enc_order_fifo

// File: rtl/encrypter_scheduler.sv
// Encrypter scheduler: hands blocks to idle cores round-robin with a
// one-cycle program pulse, collects per-core results and releases them in
// the order the blocks were accepted.
module encrypter_scheduler
  import encrypter_scheduler_pkg::*;
#(
  parameter int NUM_ENC = NUM_ENCRYPTERS,
  parameter int DATA_W  = ENCRYPTER_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  encrypter_scheduler_if.slave  bus
);

  localparam int IDX_W = $clog2(NUM_ENC);

  // Core bookkeeping
  logic [NUM_ENC-1:0] inflight_q,  inflight_d;
  logic [NUM_ENC-1:0] res_valid_q, res_valid_d;
  logic [DATA_W-1:0]  res_buf_q [NUM_ENC];
  logic [DATA_W-1:0]  res_buf_d [NUM_ENC];
  logic [IDX_W-1:0]   rr_ptr_q,    rr_ptr_d;
  logic               err_q,       err_d;

  // Program bus registers
  logic [NUM_ENC-1:0] prog_q,      prog_d;
  logic [DATA_W-1:0]  enc_data_q,  enc_data_d;
  logic [DATA_W-1:0]  enc_key_q,   enc_key_d;

  // Combinational handshake terms
  logic [NUM_ENC-1:0] eligible_s;
  logic               sel_found_s;
  logic [IDX_W-1:0]   sel_idx_s;
  logic [NUM_ENC-1:0] sel_mask_s;
  logic [NUM_ENC-1:0] head_mask_s;
  logic               blk_ready_s;
  logic               accept_s;
  logic               out_valid_s;
  logic               pop_s;
  logic               fifo_full_s;
  logic               fifo_empty_s;
  logic [IDX_W-1:0]   fifo_head_s;

  // First eligible core scanning from start upward, wrapping; MSB is the found flag
  function automatic logic [IDX_W:0] rr_pick(input logic [NUM_ENC-1:0] elig,
                                             input logic [IDX_W-1:0]   start);
    logic             found;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] cand;
    found = 1'b0;
    idx   = start;
    for (int k = 0; k < NUM_ENC; k++) begin
      cand = start + IDX_W'(k);
      if (elig[cand] && !found) begin
        found = 1'b1;
        idx   = cand;
      end else begin
        found = found;
      end
    end
    return {found, idx};
  endfunction

  enc_order_fifo #(
    .DEPTH (NUM_ENC)
  ) u_order_fifo (
    .clk      (clk),
    .rst_n    (reset),
    .push     (accept_s),
    .push_idx (sel_idx_s),
    .pop      (pop_s),
    .full     (fifo_full_s),
    .empty    (fifo_empty_s),
    .head     (fifo_head_s)
  );

  // Eligibility, core selection and both handshakes (pre-pop inflight view)
  always_comb begin
    eligible_s               = bus.enc_ready & ~inflight_q;
    {sel_found_s, sel_idx_s} = rr_pick(eligible_s, rr_ptr_q);
    sel_mask_s               = NUM_ENC'(1) << sel_idx_s;
    head_mask_s              = NUM_ENC'(1) << fifo_head_s;
    blk_ready_s              = reset & sel_found_s & ~fifo_full_s;
    accept_s                 = bus.blk_valid & blk_ready_s;
    out_valid_s              = ~fifo_empty_s & res_valid_q[fifo_head_s];
    pop_s                    = out_valid_s & bus.out_ready;
  end

  // Next-state: result capture, inflight tracking, dispatch and error flag
  always_comb begin
    res_buf_d   = res_buf_q;
    res_valid_d = res_valid_q;
    inflight_d  = inflight_q;
    rr_ptr_d    = rr_ptr_q;
    err_d       = err_q;
    prog_d      = '0;
    enc_data_d  = enc_data_q;
    enc_key_d   = enc_key_q;

    // A strobe only counts for an in-flight core whose result is still empty
    for (int i = 0; i < NUM_ENC; i++) begin
      if (bus.enc_done[i]) begin
        if (inflight_q[i] && !res_valid_q[i]) begin
          res_buf_d[i]   = bus.enc_result[i*DATA_W +: DATA_W];
          res_valid_d[i] = 1'b1;
        end else begin
          err_d = 1'b1;
        end
      end else begin
        res_valid_d[i] = res_valid_d[i];
      end
    end

    if (pop_s) begin
      inflight_d  = inflight_d  & ~head_mask_s;
      res_valid_d = res_valid_d & ~head_mask_s;
    end else begin
      inflight_d  = inflight_d;
    end

    if (accept_s) begin
      inflight_d = inflight_d | sel_mask_s;
      rr_ptr_d   = sel_idx_s + IDX_W'(1);
      prog_d     = sel_mask_s;
      enc_data_d = bus.blk_data;
      enc_key_d  = bus.blk_key_rot;
    end else begin
      prog_d     = '0;
    end
  end

  // State and output registers; reset also drops any pending program pulse
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      inflight_q  <= '0;
      res_valid_q <= '0;
      for (int i = 0; i < NUM_ENC; i++) begin
        res_buf_q[i] <= '0;
      end
      rr_ptr_q    <= '0;
      err_q       <= 1'b0;
      prog_q      <= '0;
      enc_data_q  <= '0;
      enc_key_q   <= '0;
    end else begin
      inflight_q  <= inflight_d;
      res_valid_q <= res_valid_d;
      res_buf_q   <= res_buf_d;
      rr_ptr_q    <= rr_ptr_d;
      err_q       <= err_d;
      prog_q      <= prog_d;
      enc_data_q  <= enc_data_d;
      enc_key_q   <= enc_key_d;
    end
  end

  assign bus.blk_ready    = blk_ready_s;
  assign bus.enc_program  = prog_q;
  assign bus.enc_data     = enc_data_q;
  assign bus.enc_key_rot  = enc_key_q;
  assign bus.out_valid    = out_valid_s;
  assign bus.out_data     = res_buf_q[fifo_head_s];
  assign bus.busy         = |inflight_q;
  assign bus.err_spurious = err_q;

endmodule : encrypter_scheduler

// File: tb/tb_encrypter_scheduler.sv
// Directed self-checking bench for encrypter_scheduler (4 cores, 32-bit).
module tb_encrypter_scheduler;
  import encrypter_scheduler_pkg::*;

  localparam int N = 4;
  localparam int W = 32;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  encrypter_scheduler_if #(.NUM_ENC(N), .DATA_W(W)) bus ();

  encrypter_scheduler #(.NUM_ENC(N), .DATA_W(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Move to 1 time unit after the next rising edge (input drive window)
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs follow freshly driven inputs
  task automatic settle();
    #1;
  endtask

  task automatic set_result(input int core, input logic [W-1:0] v);
    bus.enc_result[core*W +: W] = v;
  endtask

  logic [N-1:0] exp_prog;
  int           exp_core;

  initial begin
    bus.blk_valid   = 1'b1;
    bus.blk_data    = 32'h0;
    bus.blk_key_rot = 32'h0;
    bus.enc_ready   = 4'hF;
    bus.enc_done    = 4'h0;
    bus.enc_result  = '0;
    bus.out_ready   = 1'b0;

    // Reset: outputs idle even with a block offered and all cores ready
    #1 reset = 1'b0;
    settle();
    check_eq("rst_blk_ready", 64'(bus.blk_ready), 64'h0);
    check_eq("rst_out_valid", 64'(bus.out_valid), 64'h0);
    check_eq("rst_busy", 64'(bus.busy), 64'h0);
    check_eq("rst_prog", 64'(bus.enc_program), 64'h0);
    check_eq("rst_err", 64'(bus.err_spurious), 64'h0);
    next_cycle();
    next_cycle();
    reset         = 1'b1;
    bus.blk_valid = 1'b0;
    settle();
    check_eq("post_rst_blk_ready", 64'(bus.blk_ready), 64'h1);

    // Four back-to-back blocks to cores 0..3
    bus.blk_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.blk_data    = 32'h1000_0000 + 32'(i);
      bus.blk_key_rot = 32'h2000_0000 + 32'(i);
      settle();
      check_eq("b2b_blk_ready", 64'(bus.blk_ready), 64'h1);
      next_cycle();
      exp_prog = 4'b0001 << i;
      check_eq("b2b_prog", 64'(bus.enc_program), 64'(exp_prog));
      check_eq("b2b_data", 64'(bus.enc_data), 64'h1000_0000 + 64'(i));
      check_eq("b2b_key", 64'(bus.enc_key_rot), 64'h2000_0000 + 64'(i));
    end
    check_eq("full_blk_ready", 64'(bus.blk_ready), 64'h0);
    check_eq("full_busy", 64'(bus.busy), 64'h1);
    bus.blk_valid = 1'b0;
    next_cycle();
    check_eq("pulse_one_cycle", 64'(bus.enc_program), 64'h0);
    check_eq("data_held", 64'(bus.enc_data), 64'h1000_0003);

    // All four finish at once, drain in order
    for (int c = 0; c < 4; c++) set_result(c, 32'hC000_0000 + 32'(c));
    bus.enc_done = 4'hF;
    next_cycle();
    bus.enc_done  = 4'h0;
    bus.out_ready = 1'b1;
    settle();
    for (int i = 0; i < 4; i++) begin
      check_eq("drain_valid", 64'(bus.out_valid), 64'h1);
      check_eq("drain_data", 64'(bus.out_data), 64'hC000_0000 + 64'(i));
      next_cycle();
    end
    check_eq("drain_empty", 64'(bus.out_valid), 64'h0);
    check_eq("drain_idle", 64'(bus.busy), 64'h0);
    bus.out_ready = 1'b0;

    // Only cores 1 and 3 ready
    bus.enc_ready = 4'b1010;
    bus.blk_valid = 1'b1;
    bus.blk_data  = 32'h2222_0001;
    settle();
    next_cycle();
    check_eq("rr_core1", 64'(bus.enc_program), 64'b0010);
    bus.blk_data = 32'h2222_0003;
    settle();
    next_cycle();
    check_eq("rr_core3", 64'(bus.enc_program), 64'b1000);
    check_eq("rr_data", 64'(bus.enc_data), 64'h2222_0003);
    bus.blk_valid = 1'b0;
    settle();
    check_eq("rr_none_eligible", 64'(bus.blk_ready), 64'h0);
    bus.enc_ready = 4'hF;
    set_result(1, 32'hD000_0001);
    set_result(3, 32'hD000_0003);
    bus.enc_done = 4'b1010;
    next_cycle();
    bus.enc_done  = 4'h0;
    bus.out_ready = 1'b1;
    settle();
    check_eq("rr_out1", 64'(bus.out_data), 64'hD000_0001);
    next_cycle();
    check_eq("rr_out3", 64'(bus.out_data), 64'hD000_0003);
    next_cycle();
    bus.out_ready = 1'b0;
    check_eq("rr_drained", 64'(bus.out_valid), 64'h0);

    // Out-of-order completion; rr pointer wrapped back to core 0
    bus.blk_valid = 1'b1;
    bus.blk_data  = 32'hA;
    settle();
    next_cycle();
    check_eq("ooo_core0_wrap", 64'(bus.enc_program), 64'b0001);
    bus.blk_data = 32'hB;
    settle();
    next_cycle();
    check_eq("ooo_core1", 64'(bus.enc_program), 64'b0010);
    bus.blk_valid = 1'b0;
    set_result(1, 32'hBBBB_0001);
    bus.enc_done = 4'b0010;
    settle();
    check_eq("ooo_wait_a", 64'(bus.out_valid), 64'h0);
    next_cycle();
    bus.enc_done = 4'h0;
    settle();
    check_eq("ooo_wait_b", 64'(bus.out_valid), 64'h0);
    set_result(0, 32'hAAAA_0000);
    bus.enc_done  = 4'b0001;
    bus.out_ready = 1'b1;
    settle();
    check_eq("ooo_not_same_cycle", 64'(bus.out_valid), 64'h0);
    next_cycle();
    bus.enc_done = 4'h0;
    settle();
    check_eq("ooo_first_valid", 64'(bus.out_valid), 64'h1);
    check_eq("ooo_first_data", 64'(bus.out_data), 64'hAAAA_0000);
    next_cycle();
    check_eq("ooo_second_valid", 64'(bus.out_valid), 64'h1);
    check_eq("ooo_second_data", 64'(bus.out_data), 64'hBBBB_0001);
    next_cycle();
    bus.out_ready = 1'b0;
    check_eq("ooo_done", 64'(bus.out_valid), 64'h0);

    // Full array starting at core 2, single pop frees core 2
    bus.blk_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.blk_data = 32'h4444_0000 + 32'(i);
      settle();
      next_cycle();
      exp_core = (2 + i) % 4;
      exp_prog = 4'b0001 << exp_core;
      check_eq("full_prog", 64'(bus.enc_program), 64'(exp_prog));
    end
    bus.blk_valid = 1'b0;
    settle();
    check_eq("full_no_ready", 64'(bus.blk_ready), 64'h0);
    for (int c = 0; c < 4; c++) set_result(c, 32'h5555_0000 + 32'(c));
    bus.enc_done = 4'hF;
    next_cycle();
    bus.enc_done = 4'h0;
    settle();
    check_eq("full_head_data", 64'(bus.out_data), 64'h5555_0002);
    check_eq("full_still_blocked", 64'(bus.blk_ready), 64'h0);
    bus.out_ready = 1'b1;
    next_cycle();
    bus.out_ready = 1'b0;
    settle();
    check_eq("one_pop_ready", 64'(bus.blk_ready), 64'h1);
    check_eq("one_pop_head", 64'(bus.out_data), 64'h5555_0003);
    bus.blk_valid = 1'b1;
    bus.blk_data  = 32'h4444_0009;
    settle();
    next_cycle();
    bus.blk_valid = 1'b0;
    check_eq("freed_core2", 64'(bus.enc_program), 64'b0100);
    bus.out_ready = 1'b1;
    settle();
    for (int i = 0; i < 3; i++) begin
      exp_core = (3 + i) % 4;
      check_eq("full_drain", 64'(bus.out_data), 64'h5555_0000 + 64'(exp_core));
      next_cycle();
    end
    check_eq("core2_pending", 64'(bus.out_valid), 64'h0);
    check_eq("core2_busy", 64'(bus.busy), 64'h1);
    set_result(2, 32'h6666_0002);
    bus.enc_done = 4'b0100;
    next_cycle();
    bus.enc_done = 4'h0;
    settle();
    check_eq("core2_data", 64'(bus.out_data), 64'h6666_0002);
    next_cycle();
    bus.out_ready = 1'b0;
    check_eq("all_idle", 64'(bus.busy), 64'h0);

    // Spurious strobe from idle core 2
    bus.enc_done = 4'b0100;
    settle();
    check_eq("spur_not_yet", 64'(bus.err_spurious), 64'h0);
    next_cycle();
    bus.enc_done = 4'h0;
    settle();
    check_eq("spur_set", 64'(bus.err_spurious), 64'h1);
    check_eq("spur_no_valid", 64'(bus.out_valid), 64'h0);
    next_cycle();
    next_cycle();
    next_cycle();
    check_eq("spur_sticky", 64'(bus.err_spurious), 64'h1);

    // Reset mid-flight: three cores busy, program pulse on the bus
    bus.blk_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.blk_data = 32'h7000_0000 + 32'(i);
      settle();
      next_cycle();
      exp_core = (3 + i) % 4;
      exp_prog = 4'b0001 << exp_core;
      check_eq("mid_prog", 64'(bus.enc_program), 64'(exp_prog));
    end
    bus.blk_valid = 1'b0;
    reset         = 1'b0;
    settle();
    check_eq("mid_rst_prog", 64'(bus.enc_program), 64'h0);
    check_eq("mid_rst_data", 64'(bus.enc_data), 64'h0);
    check_eq("mid_rst_key", 64'(bus.enc_key_rot), 64'h0);
    check_eq("mid_rst_busy", 64'(bus.busy), 64'h0);
    check_eq("mid_rst_err", 64'(bus.err_spurious), 64'h0);
    check_eq("mid_rst_ready", 64'(bus.blk_ready), 64'h0);
    check_eq("mid_rst_valid", 64'(bus.out_valid), 64'h0);
    next_cycle();
    reset         = 1'b1;
    bus.blk_valid = 1'b1;
    bus.blk_data  = 32'h7777_7777;
    settle();
    next_cycle();
    bus.blk_valid = 1'b0;
    check_eq("post_rst_core0", 64'(bus.enc_program), 64'b0001);
    check_eq("post_rst_data", 64'(bus.enc_data), 64'h7777_7777);
    next_cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_encrypter_scheduler

// File: doc/encrypter_scheduler.md
Name: encrypter_scheduler

Overview:
Dispatches plaintext blocks to a bank of NUM_ENC encrypter cores.
- Selects a free core round-robin, issues a one-cycle program pulse with data and key rotation on a shared bus, and tracks in-flight order.
- Re-sequences core results so they leave in acceptance order.
- Sits between the QSPI parallelizer front end (upstream) and the encrypter array / output serializer (downstream).

Parameters:
NUM_ENC, 4, number of encrypter cores (power of two, ≥2); defaults from shared constant NUM_ENCRYPTERS
DATA_W, 32, block/key-rotation width; defaults from shared constant ENCRYPTER_WIDTH
IDX_W, $clog2(NUM_ENC), core index width (derived, not overridden)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
blk_valid  in  1  upstream block available
blk_ready  out  1  scheduler can accept a block this cycle
blk_data  in  DATA_W  plaintext block
blk_key_rot  in  DATA_W  key rotation for this block
enc_ready  in  NUM_ENC  per-core idle flag
enc_program  out  NUM_ENC  one-hot, one-cycle load pulse
enc_data  out  DATA_W  shared data bus, valid with enc_program
enc_key_rot  out  DATA_W  shared key-rotation bus, valid with enc_program
enc_done  in  NUM_ENC  per-core one-cycle result strobe
enc_result  in  NUM_ENC*DATA_W  flattened results; core i at bits [i*DATA_W +: DATA_W]
out_valid  out  1  in-order result available
out_ready  in  1  downstream accepts result
out_data  out  DATA_W  result at head of order queue
busy  out  1  any core in flight or any result pending
err_spurious  out  1  sticky: enc_done from a core not in flight

Behaviour:
- Reset (reset=0, async): inflight, res_valid, order queue, rr_ptr=0, enc_program=0, enc_data=0, enc_key_rot=0, err_spurious=0. blk_ready, out_valid and busy evaluate to 0. A pending program pulse is dropped.
- Eligible core: enc_ready[i] & ~inflight[i]. blk_ready = |eligible & ~queue_full. Combinational; must not depend on blk_valid.
- Select: first eligible index scanning rr_ptr, rr_ptr+1, … mod NUM_ENC.
- Accept on blk_valid & blk_ready at edge T:
  - inflight[sel]=1; sel pushed to order queue; rr_ptr=sel+1 mod NUM_ENC.
  - At T+1: enc_program = onehot(sel) for exactly one cycle; enc_data/enc_key_rot registered from blk_*, held until next accept.
- Back-to-back accepts are allowed every cycle while eligible cores remain.
- Capture on enc_done[i]:
  - If inflight[i]: res_buf[i] = enc_result slice, res_valid[i]=1.
  - If ~inflight[i] or res_valid[i] already 1: ignore the strobe and set err_spurious.
- Output:
  - out_valid = queue nonempty & res_valid[head]; out_data = res_buf[head] (registered source, zero added latency).
  - Pop on out_valid & out_ready: dequeue; clear inflight[head] and res_valid[head].
- Simultaneous events:
  - Pop and accept in the same cycle: eligibility uses pre-pop inflight, so the popped core is not reusable until the next cycle.
  - Pop and enc_done on different cores are independent.
  - enc_done on the head core while out_ready=1: out_valid rises next cycle, not same cycle.
- Out-of-order completion: later results wait in res_buf until earlier ones pop. Minimum latency enc_done→out_valid is 1 cycle.
- Full: all NUM_ENC cores in flight → blk_ready=0 until a pop. Order queue depth = NUM_ENC, so it can never overflow.
- Wrap-around: rr_ptr and queue pointers wrap mod NUM_ENC. Queue full/empty uses an extra pointer bit.
- busy = |inflight.

Decomposition:
- Shared constants file supplies NUM_ENCRYPTERS and ENCRYPTER_WIDTH; no new shared typedefs.
- One sub-module: enc_order_fifo, a synchronous FIFO of IDX_W-bit indices, depth NUM_ENC, async active-low reset, with push/pop/full/empty/head.
- Round-robin pick stays inline as a function.

Test Plan:
- Reset then 4 blocks back-to-back, all enc_ready=1 → enc_program 0001,0010,0100,1000 on consecutive cycles; blk_ready=0 after the 4th accept.
- enc_ready=4'b1010, rr_ptr=0, one block → core 1 programmed; next block → core 3; rr_ptr wraps to 0.
- Dispatch A→core0, B→core1; enc_done core1 (0xBBBB0001) before core0 (0xAAAA0000) → out_data 0xAAAA0000 first, then 0xBBBB0001; out_valid stays low until core0 done.
- All cores in flight with out_ready=0 → blk_ready=0; pulse out_ready one cycle → exactly one pop, blk_ready=1 next cycle, freed core selected.
- enc_done[2] while core 2 idle → err_spurious=1 and sticky; out_valid unaffected; cleared only by reset.
- Assert reset low mid-flight with 3 cores busy and a program pulse due → all outputs 0 immediately; after release the first accept goes to core 0.
